// File: rtl/mult_div_unit.sv
// Multicycle signed multiply (shift-add) / divide (restoring) engine with Hi/Lo result registers.
// Optional MULT_DIV_FAST_ZERO_EN: zero-operand operations finish in one cycle instead of WIDTH.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, MULT, DIV, DONE} state_t;

    state_t           state_reg, state_next;
    logic [CW-1:0]    cnt_reg;
    logic [WIDTH-1:0] upper_reg, lower_reg, bmag_reg, hi_reg, lo_reg;
    logic             neg_prod_reg, neg_rem_reg, div_zero_reg;

    logic [WIDTH-1:0] a_mag, b_mag;
    logic             a_zero, b_zero, fast_zero, last_iter;

    assign a_mag     = a[WIDTH-1] ? -a : a;
    assign b_mag     = b[WIDTH-1] ? -b : b;
    assign a_zero    = (a == '0);
    assign b_zero    = (b == '0);
    assign last_iter = (cnt_reg == CW'(WIDTH - 1));

`ifdef MULT_DIV_FAST_ZERO_EN
    assign fast_zero = (!op && (a_zero || b_zero)) || (op && a_zero && !b_zero);
`else
    assign fast_zero = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_reg <= IDLE;
        else      state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (start) begin
                if ((op && b_zero) || fast_zero) state_next = DONE;
                else                             state_next = op ? DIV : MULT;
            end
            MULT, DIV: if (last_iter) state_next = DONE;
            DONE:      state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    // One iteration of either algorithm; upper holds the partial product high half or the remainder.
    logic [WIDTH:0]     mul_sum, div_shift;
    logic [WIDTH-1:0]   div_rem, upper_next, lower_next, hi_final, lo_final;
    logic [2*WIDTH-1:0] prod_mag, prod_signed;
    logic               div_ge;

    always_comb begin
        mul_sum     = {1'b0, upper_reg} + (lower_reg[0] ? {1'b0, bmag_reg} : '0);
        div_shift   = {upper_reg, lower_reg[WIDTH-1]};
        div_ge      = (div_shift >= {1'b0, bmag_reg});
        div_rem     = div_ge ? WIDTH'(div_shift - {1'b0, bmag_reg}) : div_shift[WIDTH-1:0];
        if (state_reg == MULT) begin
            upper_next = mul_sum[WIDTH:1];
            lower_next = {mul_sum[0], lower_reg[WIDTH-1:1]};
        end else begin
            upper_next = div_rem;
            lower_next = {lower_reg[WIDTH-2:0], div_ge};
        end
        prod_mag    = {upper_next, lower_next};
        prod_signed = neg_prod_reg ? -prod_mag : prod_mag;
        if (state_reg == MULT) begin
            hi_final = prod_signed[2*WIDTH-1:WIDTH];
            lo_final = prod_signed[WIDTH-1:0];
        end else begin
            hi_final = neg_rem_reg  ? -upper_next : upper_next;
            lo_final = neg_prod_reg ? -lower_next : lower_next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_reg      <= '0;
            upper_reg    <= '0;
            lower_reg    <= '0;
            bmag_reg     <= '0;
            hi_reg       <= '0;
            lo_reg       <= '0;
            neg_prod_reg <= 1'b0;
            neg_rem_reg  <= 1'b0;
            div_zero_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: if (start) begin
                    upper_reg    <= '0;
                    lower_reg    <= a_mag;
                    bmag_reg     <= b_mag;
                    neg_prod_reg <= a[WIDTH-1] ^ b[WIDTH-1];
                    neg_rem_reg  <= a[WIDTH-1];
                    div_zero_reg <= op && b_zero;
                    cnt_reg      <= '0;
                    if (fast_zero) begin
                        hi_reg <= '0;
                        lo_reg <= '0;
                    end
                end
                MULT, DIV: begin
                    upper_reg <= upper_next;
                    lower_reg <= lower_next;
                    cnt_reg   <= cnt_reg + CW'(1);
                    if (last_iter) begin
                        hi_reg  <= hi_final;
                        lo_reg  <= lo_final;
                        cnt_reg <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy     = (state_reg == MULT) || (state_reg == DIV);
    assign done     = (state_reg == DONE);
    assign div_zero = div_zero_reg;
    assign hi       = hi_reg;
    assign lo       = lo_reg;
endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: driver pushes model results, monitor pops on each done pulse.
module tb_mult_div_unit;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic         op = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy, done, div_zero;
    logic [W-1:0] hi, lo;

    mult_div_unit #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
        int           lat;
        int           t0;
    } exp_t;

    exp_t         exp_q[$];
    exp_t         mon_e;
    int           cyc = 0;
    int           checks = 0;
    int           errors = 0;
    int           busy_cnt = 0;
    logic [W-1:0] mdl_hi = '0;
    logic [W-1:0] mdl_lo = '0;

    always @(posedge clk) cyc++;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // Monitor: compares every done pulse against the oldest expected result.
    always @(negedge clk) begin
        if (!rst) begin
            busy_cnt = 0;
        end else begin
            if (busy) busy_cnt++;
            if (done) begin
                check("done_with_busy", {63'd0, busy}, 64'd0);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done=1 expected no pending op (cycle %0d)", cyc);
                end else begin
                    mon_e = exp_q.pop_front();
                    $display("txn op=%0d a=%h b=%h -> hi=%h lo=%h dz=%b lat=%0d busy_cycles=%0d",
                             mon_e.op, mon_e.a, mon_e.b, hi, lo, div_zero, cyc - mon_e.t0, busy_cnt);
                    check("hi", {32'd0, hi}, {32'd0, mon_e.hi});
                    check("lo", {32'd0, lo}, {32'd0, mon_e.lo});
                    check("div_zero", {63'd0, div_zero}, {63'd0, mon_e.dz});
                    check("latency", 64'(cyc - mon_e.t0), 64'(mon_e.lat));
                    check("busy_cycles", 64'(busy_cnt), 64'(mon_e.lat == 33 ? 32 : 0));
                end
                busy_cnt = 0;
            end
        end
    end

    task automatic issue(input logic o, input logic [W-1:0] aa, input logic [W-1:0] bb,
                         input bit pulse, input bit abort);
        exp_t   e;
        longint sa, sb, p, q, r;
        bit     done_ok;
        sa = longint'(signed'(aa));
        sb = longint'(signed'(bb));
        e.op = o; e.a = aa; e.b = bb;
        e.dz = o && (bb == '0);
        e.lat = 33;
        if (!o) begin
            p = sa * sb;
            e.hi = p[63:32];
            e.lo = p[31:0];
        end else if (bb == '0) begin
            e.hi = mdl_hi;
            e.lo = mdl_lo;
            e.lat = 1;
        end else begin
            q = sa / sb;
            r = sa % sb;
            e.hi = r[31:0];
            e.lo = q[31:0];
        end
`ifdef MULT_DIV_FAST_ZERO_EN
        if ((!o && (aa == '0 || bb == '0)) || (o && aa == '0 && bb != '0)) e.lat = 1;
`endif
        mdl_hi = e.hi;
        mdl_lo = e.lo;

        @(negedge clk);
        start = 1'b1; op = o; a = aa; b = bb;
        e.t0 = cyc;
        exp_q.push_back(e);
        @(negedge clk);
        start = 1'b0; op = 1'($urandom); a = $urandom; b = $urandom;
        if (pulse) begin
            repeat (4) @(negedge clk);
            start = 1'b1; op = ~o; a = $urandom; b = $urandom;
            @(negedge clk);
            start = 1'b0;
        end
        if (abort) begin
            while (cyc < e.t0 + 10) @(negedge clk);
            rst = 1'b0;
            #1;
            check("abort_busy", {63'd0, busy}, 64'd0);
            check("abort_done", {63'd0, done}, 64'd0);
            check("abort_hi", {32'd0, hi}, 64'd0);
            check("abort_lo", {32'd0, lo}, 64'd0);
            exp_q.delete();
            mdl_hi = '0;
            mdl_lo = '0;
            repeat (2) @(negedge clk);
            rst = 1'b1;
            return;
        end
        done_ok = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if (exp_q.size() == 0) begin
                done_ok = 1'b1;
                break;
            end
            @(negedge clk);
            #1;
        end
        if (!done_ok) begin
            checks++;
            errors++;
            $display("FAIL timeout: got no done expected done within 100 cycles (cycle %0d)", cyc);
            exp_q.delete();
        end
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        logic         ro;
        repeat (2) @(negedge clk);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_div_zero", {63'd0, div_zero}, 64'd0);
        check("rst_hi", {32'd0, hi}, 64'd0);
        check("rst_lo", {32'd0, lo}, 64'd0);
        rst = 1'b1;

        issue(1'b0, 32'd7, 32'hFFFFFFFD, 0, 0);
        issue(1'b1, 32'hFFFFFFF9, 32'd2, 0, 0);
        issue(1'b1, 32'h451, 32'h20, 0, 0);          // leaves hi = 0x11, lo = 0x22
        issue(1'b1, 32'd5, 32'd0, 0, 0);
        issue(1'b0, 32'd2, 32'd3, 0, 0);
        issue(1'b1, 32'h80000000, 32'hFFFFFFFF, 0, 0);
        issue(1'b0, 32'h80000000, 32'h80000000, 0, 0);
        issue(1'b0, 32'h1234ABCD, 32'h55, 1, 0);
        issue(1'b1, 32'hDEADBEEF, 32'h1234, 1, 0);
        issue(1'b0, 32'h12345678, 32'h9ABC, 0, 1);
        issue(1'b1, 32'd9, 32'd0, 0, 0);
        issue(1'b0, 32'd100, 32'hFFFFFFFB, 0, 0);
        issue(1'b0, 32'd0, 32'h1234, 0, 0);
        issue(1'b1, 32'd0, 32'd7, 0, 0);
        issue(1'b1, 32'h80000000, 32'd1, 0, 0);

        for (int i = 0; i < 40; i++) begin
            ro = 1'($urandom);
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 9))
                0: rb = '0;
                1: rb = '1;
                2: rb = W'($urandom_range(1, 20));
                3: ra = 32'h80000000;
                4: ra = '0;
                5: ra = W'($urandom_range(0, 1000));
                default: ;
            endcase
            issue(ro, ra, rb, 0, 0);
        end

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
